// File: rtl/reflet_float_to_int_seq_if.sv
// Handshake bundle for the float-to-int converter.
// The accept side and the result side each have their own valid/ready pair.
interface reflet_float_to_int_seq_if #(
    parameter int int_size   = 16,
    parameter int float_size = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [float_size-1:0] float_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [int_size-1:0]   int_out;
    logic                  overflow;
    logic                  invalid;

    modport master (
        output in_valid, float_in, out_ready,
        input  in_ready, out_valid, int_out, overflow, invalid
    );
    modport slave (
        input  in_valid, float_in, out_ready,
        output in_ready, out_valid, int_out, overflow, invalid
    );
endinterface

// File: rtl/reflet_float_to_int_seq.sv
// Multi-cycle float -> signed int converter, truncating toward zero.
// The mantissa is aligned one bit per cycle. Specials and saturation bypass the shifter.
module reflet_float_to_int_seq #(
    parameter int int_size   = 16,
    parameter int float_size = 32
) (
    input logic clk,
    input logic reset,
    reflet_float_to_int_seq_if.slave io
);
    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            default: return 4 * $clog2(fs) - 13;
        endcase
    endfunction

    localparam int E    = exponent_size(float_size);
    localparam int M    = float_size - E - 1;
    localparam int B    = (1 << (E - 1)) - 1;
    localparam int W    = (int_size > M + 1) ? int_size : M + 1;
    localparam int CMAX = (M > int_size) ? M : int_size;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {C_NUM, C_ZERO, C_SAT, C_NAN, C_MIN} cls_t;

    state_t state, state_nx;
    cls_t   cls, cls_nx;
    logic [W-1:0]        mag;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                dir_left, dir_nx, sign;
    logic [int_size-1:0] int_out_r, result, mag_lo, sat_val;
    logic                overflow_r, invalid_r;

    logic                f_sign;
    logic [E-1:0]        f_exp;
    logic [M-1:0]        f_mant;
    logic signed [31:0]  e;

    assign {f_sign, f_exp, f_mant} = io.float_in;
    assign e = $signed({{(32-E){1'b0}}, f_exp}) - B;

    // Classification is decided once at acceptance. Only C_NUM uses the shifter.
    always_comb begin
        cls_nx = C_NUM;
        cnt_nx = '0;
        dir_nx = 1'b0;
        if (&f_exp)
            cls_nx = (|f_mant) ? C_NAN : C_SAT;
        else if (f_exp == '0 || e < 0)
            cls_nx = C_ZERO;
        else if (f_sign && e == int_size - 1 && f_mant == '0)
            cls_nx = C_MIN;
        else if (e > int_size - 2)
            cls_nx = C_SAT;
        else if (e < M)
            cnt_nx = CW'(M - e);
        else begin
            dir_nx = 1'b1;
            cnt_nx = CW'(e - M);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io.in_valid) state_nx = SHIFT;
            SHIFT:   if (cnt == '0) state_nx = DONE;
            DONE:    if (io.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    assign mag_lo  = mag[int_size-1:0];
    assign sat_val = sign ? {1'b1, {(int_size-1){1'b0}}} : {1'b0, {(int_size-1){1'b1}}};

    always_comb begin
        case (cls)
            C_NUM:   result = sign ? -mag_lo : mag_lo;
            C_SAT:   result = sat_val;
            C_MIN:   result = {1'b1, {(int_size-1){1'b0}}};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag        <= '0;
            cnt        <= '0;
            dir_left   <= 1'b0;
            sign       <= 1'b0;
            cls        <= C_ZERO;
            int_out_r  <= '0;
            overflow_r <= 1'b0;
            invalid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    sign     <= f_sign;
                    cls      <= cls_nx;
                    cnt      <= cnt_nx;
                    dir_left <= dir_nx;
                    mag      <= W'({1'b1, f_mant});
                end
                SHIFT: if (cnt != '0) begin
                    mag <= dir_left ? (mag << 1) : (mag >> 1);
                    cnt <= cnt - CW'(1);
                end else begin
                    int_out_r  <= result;
                    overflow_r <= (cls == C_SAT);
                    invalid_r  <= (cls == C_NAN);
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.int_out   = int_out_r;
    assign io.overflow  = overflow_r;
    assign io.invalid   = invalid_r;
endmodule

// File: tb/tb_reflet_float_to_int_seq.sv
// Scoreboard bench: a real-arithmetic reference model predicts each conversion.
// A negedge monitor checks every result handshake against the queue.
module tb_reflet_float_to_int_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reflet_float_to_int_seq_if #(.int_size(16), .float_size(32)) io();
    reflet_float_to_int_seq_if #(.int_size(64), .float_size(64)) io64();

    reflet_float_to_int_seq #(.int_size(16), .float_size(32)) dut (
        .clk(clk), .reset(reset), .io(io)
    );
    reflet_float_to_int_seq #(.int_size(64), .float_size(64)) dut64 (
        .clk(clk), .reset(reset), .io(io64)
    );

    typedef struct packed {
        logic [15:0] val;
        logic        ovf;
        logic        inv;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Value-level model: build the real number, then apply C-cast truncation and range limits.
    function automatic exp_t model(input logic [31:0] f);
        exp_t r;
        real  m;
        int   ex, v;
        r = '0;
        r.lat = -1;
        ex = int'(f[30:23]);
        if (ex == 255) begin
            if (f[22:0] != 0) r.inv = 1'b1;
            else begin
                r.ovf = 1'b1;
                r.val = f[31] ? 16'h8000 : 16'h7fff;
            end
            return r;
        end
        if (ex == 0) return r;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        for (int k = 127; k < ex; k++) m = m * 2.0;
        for (int k = ex; k < 127; k++) m = m / 2.0;
        if (f[31] && m == 32768.0) r.val = 16'h8000;
        else if (m >= 32768.0) begin
            r.ovf = 1'b1;
            r.val = f[31] ? 16'h8000 : 16'h7fff;
        end else begin
            v = $rtoi(m);
            r.val = 16'(f[31] ? -v : v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (io.out_valid && !prev_ov && sb.size() > 0 && sb[0].lat >= 0)
                chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            if (io.out_valid && io.out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    cur = sb.pop_front();
                    chk("int_out", 64'(io.int_out), 64'(cur.val));
                    chk("overflow", 64'(io.overflow), 64'(cur.ovf));
                    chk("invalid", 64'(io.invalid), 64'(cur.inv));
                end
            end
        end
        prev_ov <= io.out_valid;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) io.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] f, input int lat, input bit push);
        exp_t x;
        int   t;
        t = 0;
        @(negedge clk);
        while (!io.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!io.in_ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        io.in_valid = 1'b1;
        io.float_in = f;
        if (push) begin
            x = model(f);
            x.acc = cyc + 1;
            x.lat = lat;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.float_in = $urandom;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
        @(negedge clk);
    endtask

    logic [31:0] dir_vec [12] = '{32'hC0B80000, 32'h46FFFE00, 32'h471C4000, 32'hC7000000,
                                  32'hC7000100, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                                  32'h00000001, 32'h7F800000, 32'h3FFFFFFF, 32'hC6FFFE00};

    initial begin
        int t;
        logic [31:0] f;
        int sel;
        io.in_valid = 1'b0;   io.float_in = '0;   io.out_ready = 1'b1;
        io64.in_valid = 1'b0; io64.float_in = '0; io64.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(io.in_ready), 1);
        chk("rst_out_valid", 64'(io.out_valid), 0);
        chk("rst_int_out", 64'(io.int_out), 0);
        chk("rst_overflow", 64'(io.overflow), 0);
        chk("rst_invalid", 64'(io.invalid), 0);
        reset = 1'b0;

        // 64-bit instance: exponent 52 gives a zero-length left shift.
        @(negedge clk);
        io64.in_valid = 1'b1;
        io64.float_in = 64'h4330000000000001;
        @(posedge clk);
        #1 io64.in_valid = 1'b0;
        t = 0;
        while (!io64.out_valid && t < 100) begin @(negedge clk); t++; end
        chk("w64_int_out", io64.int_out, 64'h0010000000000001);
        chk("w64_overflow", 64'(io64.overflow), 0);

        send(32'h3F800000, 24, 1);
        send(32'h3F000000, 1, 1);
        foreach (dir_vec[i]) send(dir_vec[i], -1, 1);
        wait_drain();

        // Stall with out_ready low: result must hold and no new input accepted.
        io.out_ready = 1'b0;
        send(32'h40400000, -1, 1);
        t = 0;
        while (!io.out_valid && t < 100) begin @(negedge clk); t++; end
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", 64'(io.int_out), 64'h0003);
            chk("stall_out_valid", 64'(io.out_valid), 1);
            chk("stall_in_ready", 64'(io.in_ready), 0);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(io.in_ready), 1);
        chk("release_out_valid", 64'(io.out_valid), 0);
        send(32'hC0B80000, -1, 1);
        wait_drain();

        // Reset in the middle of a shift discards the conversion.
        send(32'h3F800000, -1, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(io.out_valid), 0);
        chk("abort_int_out", 64'(io.int_out), 0);
        chk("abort_in_ready", 64'(io.in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        send(32'h40400000, -1, 1);
        wait_drain();

        ready_mode = 2;
        repeat (200) begin
            sel = int'($urandom_range(0, 9));
            f[31] = 1'($urandom_range(0, 1));
            f[30:23] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(118, 145));
            f[22:0] = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
            send(f, -1, 1);
        end
        ready_mode = 0;
        io.out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
